// File: rtl/nx_run_ctrl.sv
// Host-commanded run sequencer for the Nexus mesh: one trigger per mesh cycle, bounded/free runs, STOP/CLEAR.
// Optional watchdog compiled in with `define NX_RUN_CTRL_WATCHDOG_EN.
module nx_run_ctrl #(
    parameter int COUNTER_WIDTH = 32,
    parameter int TIMEOUT       = 4096
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               cmd_op_i,
    input  logic [COUNTER_WIDTH-1:0] cmd_arg_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    output logic                     cmd_err_o,
    input  logic                     mesh_idle_i,
    output logic                     trigger_o,
    output logic [COUNTER_WIDTH-1:0] cycle_o,
    output logic [COUNTER_WIDTH-1:0] remaining_o,
    output logic                     running_o,
    output logic                     done_o,
    output logic                     fault_o
);
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_WAIT_BUSY = 2'd2
    } state_t;

    if (TIMEOUT < 1 || COUNTER_WIDTH < 1) begin : g_bad_cfg
        $error("nx_run_ctrl: TIMEOUT and COUNTER_WIDTH must be positive");
    end

    state_t                     state_q, state_d;
    logic [COUNTER_WIDTH-1:0]   cycle_q, cycle_d;
    logic [COUNTER_WIDTH-1:0]   remaining_q, remaining_d;
    logic                       free_q, free_d;
    logic                       stop_pend_q, stop_pend_d;
    logic                       trigger_q, trigger_d;
    logic                       done_q, done_d;
    logic                       running_q, running_d;
    logic                       err_pend_q, err_pend_d;
    logic                       cmd_err_q, cmd_err_d;
    logic                       cmd_run, cmd_stop, cmd_clear;
    logic                       run_blocked;

`ifdef NX_RUN_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            fault_q, fault_d;
    assign run_blocked = fault_q;
    assign fault_o     = fault_q;
`else
    assign run_blocked = 1'b0;
    assign fault_o     = 1'b0;
`endif

    assign cmd_run   = cmd_valid_i && (cmd_op_i == OP_RUN);
    assign cmd_stop  = cmd_valid_i && (cmd_op_i == OP_STOP);
    assign cmd_clear = cmd_valid_i && (cmd_op_i == OP_CLEAR);

    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        remaining_d = remaining_q;
        free_d      = free_q;
        stop_pend_d = stop_pend_q;
        trigger_d   = 1'b0;
        done_d      = 1'b0;
        err_pend_d  = 1'b0;
        // Error pulse is delayed one clock behind the consuming edge.
        cmd_err_d   = err_pend_q;
`ifdef NX_RUN_CTRL_WATCHDOG_EN
        fault_d     = fault_q;
        wd_d        = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_run) begin
                    if (run_blocked) begin
                        err_pend_d = 1'b1;
                    end else begin
                        remaining_d = cmd_arg_i;
                        free_d      = (cmd_arg_i == '0);
                        stop_pend_d = 1'b0;
                        state_d     = ST_WAIT_IDLE;
                    end
                end else if (cmd_clear) begin
                    cycle_d = '0;
`ifdef NX_RUN_CTRL_WATCHDOG_EN
                    fault_d = 1'b0;
`endif
                end
            end
            default: begin
                if (cmd_run || cmd_clear) begin
                    err_pend_d = 1'b1;
                end
                if (cmd_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (state_q == ST_WAIT_IDLE) begin
                    if (mesh_idle_i) begin
                        if (stop_pend_q || (!free_q && remaining_q == '0)) begin
                            state_d     = ST_IDLE;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else begin
                            trigger_d = 1'b1;
                            cycle_d   = cycle_q + 1'b1;
                            if (!free_q) begin
                                remaining_d = remaining_q - 1'b1;
                            end
                            state_d = ST_WAIT_BUSY;
                        end
                    end
                end else if (!mesh_idle_i) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
        endcase

`ifdef NX_RUN_CTRL_WATCHDOG_EN
        // Timer counts clocks in an unchanged waiting state; a real transition always wins.
        if (state_q != ST_IDLE && state_d == state_q) begin
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                state_d     = ST_IDLE;
                done_d      = 1'b1;
                fault_d     = 1'b1;
                stop_pend_d = 1'b0;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
        running_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cycle_q     <= '0;
            remaining_q <= '0;
            free_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            trigger_q   <= 1'b0;
            done_q      <= 1'b0;
            running_q   <= 1'b0;
            err_pend_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            remaining_q <= remaining_d;
            free_q      <= free_d;
            stop_pend_q <= stop_pend_d;
            trigger_q   <= trigger_d;
            done_q      <= done_d;
            running_q   <= running_d;
            err_pend_q  <= err_pend_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

`ifdef NX_RUN_CTRL_WATCHDOG_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            fault_q <= fault_d;
        end
    end
`endif

    assign cmd_ready_o = 1'b1;
    assign cmd_err_o   = cmd_err_q;
    assign trigger_o   = trigger_q;
    assign cycle_o     = cycle_q;
    assign remaining_o = remaining_q;
    assign running_o   = running_q;
    assign done_o      = done_q;
endmodule

// File: tb/tb_nx_run_ctrl.sv
// Scoreboard bench for nx_run_ctrl: stimulus pushes expected trigger/done/error events, a monitor pops and compares.
module tb_nx_run_ctrl;
    localparam int CW  = 4;
    localparam int TO  = 16;
    localparam int MOD = 1 << CW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [1:0]    cmd_op_i = 2'd0;
    logic [CW-1:0] cmd_arg_i = '0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_err_o;
    logic          mesh_idle_i = 1'b1;
    logic          trigger_o;
    logic [CW-1:0] cycle_o;
    logic [CW-1:0] remaining_o;
    logic          running_o;
    logic          done_o;
    logic          fault_o;

    nx_run_ctrl #(.COUNTER_WIDTH(CW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_op_i(cmd_op_i), .cmd_arg_i(cmd_arg_i), .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o), .cmd_err_o(cmd_err_o),
        .mesh_idle_i(mesh_idle_i), .trigger_o(trigger_o),
        .cycle_o(cycle_o), .remaining_o(remaining_o),
        .running_o(running_o), .done_o(done_o), .fault_o(fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int cyc; int rem; bit flt; } ev_t;
    ev_t trig_exp[$];
    ev_t done_exp[$];
    int  err_exp[$];

    int passed = 0, total = 0;
    int model_cycle = 0;
    int trig_seen = 0, done_seen = 0, err_seen = 0;
    bit stuck = 1'b0;
    bit rand_mesh = 1'b0;

    function automatic ev_t mk(input int c, input int r, input bit f);
        ev_t e;
        e.cyc = c; e.rem = r; e.flt = f;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Mesh model: goes busy some clocks after each trigger, stays busy a while, then idles.
    initial begin
        int d, l;
        forever begin
            @(posedge clk_i); #1;
            if (trigger_o && !stuck && !rst_i) begin
                d = rand_mesh ? int'($urandom_range(1, 3)) : 2;
                l = rand_mesh ? int'($urandom_range(1, 5)) : 4;
                repeat (d - 1) @(posedge clk_i);
                #1 mesh_idle_i = 1'b0;
                repeat (l) @(posedge clk_i);
                #1 mesh_idle_i = 1'b1;
            end
        end
    end

    // Monitor: every output event must match the head of its expectation queue.
    always @(negedge clk_i) begin
        ev_t e;
        if (!rst_i) begin
            if (trigger_o) begin
                trig_seen++;
                check("trigger_expected", int'(trig_exp.size() > 0), 1);
                if (trig_exp.size() > 0) begin
                    e = trig_exp.pop_front();
                    check("trigger_cycle", int'(cycle_o), e.cyc);
                    check("trigger_remaining", int'(remaining_o), e.rem);
                end
            end
            if (done_o) begin
                done_seen++;
                check("done_expected", int'(done_exp.size() > 0), 1);
                if (done_exp.size() > 0) begin
                    e = done_exp.pop_front();
                    check("done_cycle", int'(cycle_o), e.cyc);
                    check("done_remaining", int'(remaining_o), e.rem);
                    check("done_fault", int'(fault_o), int'(e.flt));
                    check("done_running_low", int'(running_o), 0);
                end
            end
            if (cmd_err_o) begin
                err_seen++;
                check("err_expected", int'(err_exp.size() > 0), 1);
                if (err_exp.size() > 0) void'(err_exp.pop_front());
            end
        end
    end

    task automatic send(input logic [1:0] op, input int arg);
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_arg_i = arg[CW-1:0];
        @(negedge clk_i);
        cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_arg_i = '0;
    endtask

    task automatic wait_done(input string name, input int start, input int budget);
        int n = 0;
        while (done_seen == start && n < budget) begin
            @(negedge clk_i); #1; n++;
        end
        check(name, int'(done_seen != start), 1);
    endtask

    task automatic wait_trig(input string name, input int target, input int budget);
        int n = 0;
        while (trig_seen < target && n < budget) begin
            @(negedge clk_i); #1; n++;
        end
        check(name, int'(trig_seen >= target), 1);
    endtask

    // Reference: a run of n triggers advances cycle by n; bounded runs count remaining down to 0.
    task automatic expect_run(input int n, input bit bounded);
        for (int k = 1; k <= n; k++)
            trig_exp.push_back(mk((model_cycle + k) % MOD, bounded ? n - k : 0, 1'b0));
        done_exp.push_back(mk((model_cycle + n) % MOD, 0, 1'b0));
        model_cycle = (model_cycle + n) % MOD;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_trigger"}, int'(trigger_o), 0);
        check({tag, "_cycle"}, int'(cycle_o), 0);
        check({tag, "_remaining"}, int'(remaining_o), 0);
        check({tag, "_running"}, int'(running_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_err"}, int'(cmd_err_o), 0);
        check({tag, "_fault"}, int'(fault_o), 0);
        check({tag, "_ready"}, int'(cmd_ready_o), 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk_i); #2 rst_i = 1'b1;
        #1 check_reset_values("reset_async");
        trig_exp.delete(); done_exp.delete(); err_exp.delete();
        model_cycle = 0;
        @(negedge clk_i); #2 rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s, t, n;
        #1 check_reset_values("reset");
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Bounded run of 3 with fixed mesh timing, including first-trigger latency.
        s = done_seen; t = trig_seen;
        expect_run(3, 1'b1);
        send(2'd1, 3);
        #1 check("run_running_high", int'(running_o), 1);
        @(negedge clk_i); #1;
        check("first_trigger_latency", trig_seen - t, 1);
        wait_done("bounded_done", s, 60);
        check("bounded_triggers", trig_seen - t, 3);
        check("bounded_cycle", int'(cycle_o), model_cycle);
        check("bounded_remaining", int'(remaining_o), 0);
        check("bounded_running_after", int'(running_o), 0);

        // Free run stopped during the 5th busy phase.
        s = done_seen; t = trig_seen;
        expect_run(5, 1'b0);
        send(2'd1, 0);
        wait_trig("free_5th_trigger", t + 5, 80);
        send(2'd2, 0);
        wait_done("free_stop_done", s, 40);
        repeat (10) @(negedge clk_i);
        check("free_no_6th_trigger", trig_seen - t, 5);
        check("free_cycle", int'(cycle_o), model_cycle);

        // Illegal RUN and CLEAR mid-run.
        s = done_seen; t = trig_seen; n = err_seen;
        expect_run(4, 1'b1);
        err_exp.push_back(1); err_exp.push_back(1);
        send(2'd1, 4);
        wait_trig("illegal_first_trigger", t + 1, 20);
        send(2'd1, 9);
        send(2'd3, 0);
        wait_done("illegal_done", s, 80);
        repeat (3) @(negedge clk_i);
        check("illegal_err_pulses", err_seen - n, 2);
        check("illegal_triggers", trig_seen - t, 4);
        check("illegal_cycle_kept", int'(cycle_o), model_cycle);
        send(2'd3, 0);
        model_cycle = 0;
        #1 check("clear_idle_cycle", int'(cycle_o), model_cycle);

        // Stuck-idle mesh: one trigger, then the FSM waits for busy forever (or the watchdog fires).
        stuck = 1'b1;
        t = trig_seen; s = done_seen;
        trig_exp.push_back(mk((model_cycle + 1) % MOD, 1, 1'b0));
        model_cycle = (model_cycle + 1) % MOD;
`ifdef NX_RUN_CTRL_WATCHDOG_EN
        done_exp.push_back(mk(model_cycle, 1, 1'b1));
        send(2'd1, 2);
        wait_done("wd_done", s, TO + 10);
        check("wd_fault_set", int'(fault_o), 1);
        err_exp.push_back(1);
        n = err_seen;
        send(2'd1, 1);
        repeat (3) @(negedge clk_i);
        check("wd_run_refused_err", err_seen - n, 1);
        check("wd_run_refused_idle", int'(running_o), 0);
        send(2'd3, 0);
        model_cycle = 0;
        #1 check("wd_clear_fault", int'(fault_o), 0);
`else
        send(2'd1, 2);
        repeat (40) @(negedge clk_i);
        #1 check("stuck_still_running", int'(running_o), 1);
`endif
        check("stuck_single_trigger", trig_seen - t, 1);
        pulse_reset();
        stuck = 1'b0;

        // Reset during WAIT_BUSY of a RUN of 10.
        t = trig_seen; s = done_seen;
        expect_run(10, 1'b1);
        send(2'd1, 10);
        wait_trig("reset_run_trigger", t + 1, 20);
        pulse_reset();
        repeat (20) @(negedge clk_i);
        check("reset_no_done", done_seen - s, 0);

        // Counter wrap: 17 triggers from zero land on 1.
        send(2'd3, 0);
        model_cycle = 0;
        s = done_seen; t = trig_seen;
        expect_run(17, 1'b0);
        send(2'd1, 0);
        wait_trig("wrap_17th_trigger", t + 17, 200);
        send(2'd2, 0);
        wait_done("wrap_done", s, 40);
        check("wrap_cycle", int'(cycle_o), model_cycle);

        // Randomized bounded runs, random mesh timing, occasional harmless/illegal commands.
        rand_mesh = 1'b1;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 7);
            if ($urandom_range(0, 1) == 1) send(($urandom_range(0, 1) == 1) ? 2'd2 : 2'd0, 0);
            s = done_seen; t = trig_seen;
            expect_run(n, 1'b1);
            send(2'd1, n);
            if ($urandom_range(0, 1) == 1) begin
                wait_trig("rand_first_trigger", t + 1, 20);
                err_exp.push_back(1);
                send(($urandom_range(0, 1) == 1) ? 2'd1 : 2'd3, $urandom_range(0, 15));
            end
            wait_done("rand_done", s, 20 * n + 40);
            check("rand_triggers", trig_seen - t, n);
        end

        repeat (5) @(negedge clk_i);
        check("trig_queue_drained", trig_exp.size(), 0);
        check("done_queue_drained", done_exp.size(), 0);
        check("err_queue_drained", err_exp.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/nx_run_ctrl.md
# nx_run_ctrl

Run controller for the Nexus mesh. It replaces the free-running trigger loop at the top level with a host-commanded sequencer. The sequencer accepts RUN/STOP/CLEAR commands and issues one `trigger_o` pulse per simulated cycle, waiting for the mesh to go busy and then idle again between pulses. It stops after a programmed number of cycles, on request, or (optionally) on a watchdog timeout. It sits between the host control interface and `nx_mesh` (`trigger_i`/`idle_o`).

## Interface
- `COUNTER_WIDTH`, 32, width of cycle counter and run-length argument
- `TIMEOUT`, 4096, watchdog limit in clocks (used only with watchdog compiled in)
- `clk_i` in 1: single clock
- `rst_i` in 1: asynchronous, active-high reset
- `cmd_op_i` in 2: 0 NOP, 1 RUN, 2 STOP, 3 CLEAR
- `cmd_arg_i` in COUNTER_WIDTH: RUN length in cycles; 0 = free-run
- `cmd_valid_i` in 1: command valid
- `cmd_ready_o` out 1: constant 1 out of reset (commands always consumed)
- `cmd_err_o` out 1: one-clock pulse when a consumed command is illegal
- `mesh_idle_i` in 1: mesh idle (from `nx_mesh.idle_o`)
- `trigger_o` out 1: one-clock trigger to mesh
- `cycle_o` out COUNTER_WIDTH: total triggers issued since reset/CLEAR
- `remaining_o` out COUNTER_WIDTH: triggers left in a bounded run
- `running_o` out 1: high in any state other than IDLE
- `done_o` out 1: one-clock pulse when a run ends
- `fault_o` out 1: sticky watchdog fault

## Operation
- Registered FSM with states IDLE, WAIT_IDLE and WAIT_BUSY. All outputs are registered.
- A command is consumed on any edge where `cmd_valid_i` is high.
- **IDLE**
  - RUN: load `remaining` ← arg and `free` ← (arg == 0); clear `stop_pend`; go to WAIT_IDLE.
  - CLEAR: `cycle` ← 0, `fault_o` ← 0.
  - STOP or NOP: no effect, no error.
- **WAIT_IDLE**, when `mesh_idle_i` is high:
  - If `stop_pend`, or (!`free` and `remaining` == 0): go to IDLE and pulse `done_o`.
  - Otherwise: `trigger_o` ← 1, `cycle` += 1 (wraps modulo 2^COUNTER_WIDTH), `remaining` −= 1 if !`free`, go to WAIT_BUSY.
- **WAIT_BUSY**: stay until `mesh_idle_i` is low, then go to WAIT_IDLE. A trigger is never re-issued before the mesh has gone busy.
- **STOP in WAIT_IDLE or WAIT_BUSY**: set `stop_pend`. The run ends at the next idle check in WAIT_IDLE; an in-flight mesh cycle is never aborted.
- **RUN or CLEAR while running**: ignored and `cmd_err_o` pulses. State and counters are unchanged.
- **Simultaneous STOP and final idle check**: the run ends at that edge, `done_o` pulses once, and `stop_pend` is cleared.
- `remaining` never underflows; a bounded run ends exactly at 0.
- **Reset values**: state IDLE, `trigger_o` = 0, `cycle_o` = 0, `remaining_o` = 0, `running_o` = 0, `done_o` = 0, `cmd_err_o` = 0, `fault_o` = 0, `cmd_ready_o` = 1.
- Reset mid-run returns to IDLE immediately. No trigger or `done_o` is emitted.

## Timing
- RUN consumed at edge E with the mesh idle: state is WAIT_IDLE after E, `trigger_o` is high for the clock after edge E+1, and `cycle_o` updates at E+1.
- The minimum spacing between triggers is 3 clocks: trigger, busy seen, idle seen.
- `done_o` rises at the edge where WAIT_IDLE samples `mesh_idle_i` high with the end condition true. `running_o` falls at the same edge.
- `cmd_err_o` rises at the edge after the illegal command's consuming edge.

## Configuration
- `NX_RUN_CTRL_WATCHDOG_EN`
  - **Defined**: a timer counts clocks spent continuously in WAIT_BUSY or WAIT_IDLE without a state change.
    - When the count reaches `TIMEOUT`: go to IDLE, set `fault_o` sticky, and pulse `done_o`.
    - The timer clears on every state change.
    - RUN is refused while `fault_o` is set (`cmd_err_o` pulses); only CLEAR releases it.
  - **Undefined**: no timer logic, `fault_o` tied to 0, and the FSM may wait indefinitely.

## Test plan
- **Bounded run**: reset, RUN arg=3; the mesh model goes busy 2 clocks after each trigger for 4 clocks. Expect exactly 3 `trigger_o` pulses, `cycle_o` = 3, `remaining_o` = 0, one `done_o`, and `running_o` low afterwards.
- **Free run with STOP**: RUN arg=0, then STOP during the 5th WAIT_BUSY. Expect the run to end after the 5th mesh cycle, `cycle_o` = 5, one `done_o`, and no 6th trigger.
- **Illegal commands**: RUN arg=4, then RUN arg=9 and CLEAR mid-run. Expect 2 `cmd_err_o` pulses, the run still completes 4 triggers, and `cycle_o` is not cleared. CLEAR in IDLE afterwards gives `cycle_o` = 0.
- **Stuck-idle mesh**: hold `mesh_idle_i` high permanently and RUN arg=2. Expect one trigger, then no further trigger. With the watchdog compiled in and `TIMEOUT` = 16, expect `fault_o` = 1 and `done_o` after 16 clocks in WAIT_BUSY.
- **Reset mid-run**: assert `rst_i` in WAIT_BUSY of a RUN arg=10. Expect all outputs at reset values immediately and no `done_o`.
- **Counter wrap**: with `COUNTER_WIDTH` = 4, CLEAR, then RUN arg=0 for 17 triggers. Expect `cycle_o` to wrap 15 → 0 and read 1 at the end.
